// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: decoupled instruction fetch with a packet FIFO.
//   PC side    : pc_next/predict_valid_next in, pc_fetch_now_process and
//                pc_next_been_accept out; branch_occur/branch_target redirect.
//   Cache side : icache_read_request/icache_pc/icache_flush out,
//                icache_accept, icache_data_valid, icache_inst in.
//   Decode side: fetch_valid/fetch_pc/fetch_inst/fetch_predict_valid and
//                fetch_occupancy out, fetch_result_been_accepted in.
// Up to MAX_OUTSTANDING reads are in flight. After a redirect, responses to
// older reads are swallowed by a drop counter instead of being cancelled.
module riscv_fetch_queue #(
  parameter int unsigned FETCH_WORDS     = 2,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic [31:0]                    pc_next,
  input  logic                           predict_valid_next,
  output logic [31:0]                    pc_fetch_now_process,
  output logic                           pc_next_been_accept,
  input  logic                           branch_occur,
  input  logic [31:0]                    branch_target,
  output logic                           icache_read_request,
  input  logic                           icache_accept,
  output logic [31:0]                    icache_pc,
  output logic                           icache_flush,
  input  logic                           icache_data_valid,
  input  logic [32*FETCH_WORDS-1:0]      icache_inst,
  output logic                           fetch_valid,
  output logic [31:0]                    fetch_pc,
  output logic [32*FETCH_WORDS-1:0]      fetch_inst,
  output logic                           fetch_predict_valid,
  input  logic                           fetch_result_been_accepted,
  output logic [$clog2(QUEUE_DEPTH):0]   fetch_occupancy
);

  localparam int unsigned W        = 32 * FETCH_WORDS;
  localparam int unsigned QW       = $clog2(QUEUE_DEPTH);
  localparam int unsigned OW       = QW + 1;
  localparam int unsigned TW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] OFF_MASK = 32'(4 * FETCH_WORDS - 1);

  logic [31:0]   r_pc_process;
  logic          r_pend;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_drop;
  logic [OW-1:0] r_occ;
  logic [QW-1:0] r_q_rd;
  logic [QW-1:0] r_q_wr;
  logic [W-1:0]  r_q_inst [QUEUE_DEPTH];
  logic [31:0]   r_q_pc   [QUEUE_DEPTH];
  logic          r_q_pred [QUEUE_DEPTH];
  logic [TW-1:0] r_t_rd;
  logic [TW-1:0] r_t_wr;
  logic [31:0]   r_t_pc   [MAX_OUTSTANDING];
  logic          r_t_pred [MAX_OUTSTANDING];

  logic [31:0] w_eff_pc;
  logic        w_pred;
  logic [31:0] w_inflight;
  logic [31:0] w_reserved;
  logic        w_req;
  logic        w_acc;
  logic        w_resp_drop;
  logic        w_resp_live;
  logic        w_keep;
  logic        w_pop;

  function automatic logic [TW-1:0] t_inc(input logic [TW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
  endfunction

  always_comb begin
    w_eff_pc    = branch_occur ? branch_target : r_pc_process;
    w_pred      = branch_occur | r_pend | predict_valid_next;
    w_inflight  = 32'(r_live) + 32'(r_drop);
    // A redirect frees every queue slot and live reservation this cycle.
    w_reserved  = branch_occur ? '0 : (32'(r_occ) + 32'(r_live));
    w_req       = (w_inflight < MAX_OUTSTANDING) && (w_reserved < QUEUE_DEPTH);
    w_acc       = w_req && icache_accept;
    w_resp_drop = icache_data_valid && (r_drop != '0);
    w_resp_live = icache_data_valid && (r_drop == '0) && (r_live != '0);
    w_keep      = w_resp_live && !branch_occur;
    w_pop       = (r_occ != '0) && fetch_result_been_accepted && !branch_occur;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_pc_process <= RESET_PC;
      r_pend       <= 1'b0;
      r_live       <= '0;
      r_drop       <= '0;
      r_occ        <= '0;
      r_q_rd       <= '0;
      r_q_wr       <= '0;
      r_t_rd       <= '0;
      r_t_wr       <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
        r_q_pred[i] <= 1'b0;
      end
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        r_t_pc[i]   <= '0;
        r_t_pred[i] <= 1'b0;
      end
    end else begin
      if (w_acc) begin
        r_pc_process <= pc_next;
        r_pend       <= 1'b0;
      end else if (branch_occur) begin
        r_pc_process <= branch_target;
        r_pend       <= 1'b1;
      end

      if (branch_occur) begin
        // Every live read becomes a dropped read; a response arriving now
        // retires one of them whichever counter it was charged to.
        r_drop <= r_drop + r_live - CW'(w_resp_drop | w_resp_live);
        r_live <= w_acc ? CW'(1) : '0;
        r_t_rd <= '0;
        r_t_wr <= w_acc ? t_inc('0) : '0;
        if (w_acc) begin
          r_t_pc[0]   <= w_eff_pc;
          r_t_pred[0] <= w_pred;
        end
        r_occ  <= '0;
        r_q_rd <= '0;
        r_q_wr <= '0;
      end else begin
        r_drop <= r_drop - CW'(w_resp_drop);
        r_live <= r_live + CW'(w_acc) - CW'(w_keep);
        if (w_acc) begin
          r_t_pc[r_t_wr]   <= w_eff_pc;
          r_t_pred[r_t_wr] <= w_pred;
          r_t_wr           <= t_inc(r_t_wr);
        end
        if (w_keep) begin
          r_q_inst[r_q_wr] <= icache_inst;
          r_q_pc[r_q_wr]   <= r_t_pc[r_t_rd];
          r_q_pred[r_q_wr] <= r_t_pred[r_t_rd];
          r_q_wr           <= r_q_wr + QW'(1);
          r_t_rd           <= t_inc(r_t_rd);
        end
        if (w_pop) begin
          r_q_rd <= r_q_rd + QW'(1);
        end
        r_occ <= r_occ + OW'(w_keep) - OW'(w_pop);
      end
    end
  end

  assign pc_fetch_now_process = w_eff_pc;
  assign pc_next_been_accept  = w_acc;
  assign icache_read_request  = w_req;
  assign icache_pc            = w_eff_pc & ~OFF_MASK;
  assign icache_flush         = branch_occur;
  assign fetch_valid          = (r_occ != '0);
  assign fetch_pc             = r_q_pc[r_q_rd];
  assign fetch_inst           = r_q_inst[r_q_rd];
  assign fetch_predict_valid  = r_q_pred[r_q_rd];
  assign fetch_occupancy      = r_occ;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
module tb_riscv_fetch_queue;

  localparam int unsigned QD    = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RST_PC = 32'h100;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [63:0] inst;
  } pkt_t;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } creq_t;

  logic        clk = 1'b0;
  logic        srst;
  logic [31:0] pc_next;
  logic        predict_valid_next;
  logic [31:0] pc_fetch_now_process;
  logic        pc_next_been_accept;
  logic        branch_occur;
  logic [31:0] branch_target;
  logic        icache_read_request;
  logic        icache_accept;
  logic [31:0] icache_pc;
  logic        icache_flush;
  logic        icache_data_valid;
  logic [63:0] icache_inst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [63:0] fetch_inst;
  logic        fetch_predict_valid;
  logic        fetch_result_been_accepted;
  logic [2:0]  fetch_occupancy;

  riscv_fetch_queue #(
    .FETCH_WORDS(2),
    .QUEUE_DEPTH(QD),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .srst(srst),
    .pc_next(pc_next),
    .predict_valid_next(predict_valid_next),
    .pc_fetch_now_process(pc_fetch_now_process),
    .pc_next_been_accept(pc_next_been_accept),
    .branch_occur(branch_occur),
    .branch_target(branch_target),
    .icache_read_request(icache_read_request),
    .icache_accept(icache_accept),
    .icache_pc(icache_pc),
    .icache_flush(icache_flush),
    .icache_data_valid(icache_data_valid),
    .icache_inst(icache_inst),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .fetch_inst(fetch_inst),
    .fetch_predict_valid(fetch_predict_valid),
    .fetch_result_been_accepted(fetch_result_been_accepted),
    .fetch_occupancy(fetch_occupancy)
  );

  always #5 clk = ~clk;

  // Sequential PC stage: next aligned packet after the one being fetched.
  assign pc_next = (pc_fetch_now_process & ~32'h7) + 32'd8;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  pkt_t        sb[$];
  creq_t       cq[$];
  logic [31:0] exp_pc;
  logic        pend;

  function automatic logic [63:0] mkdata(input logic [31:0] pc);
    logic [31:0] a;
    a = pc & ~32'h7;
    return {a ^ 32'hC0DE_0000, ~a + 32'h1234};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    srst              = 1'b1;
    branch_occur      = 1'b0;
    icache_data_valid = 1'b0;
    icache_inst       = '0;
    @(posedge clk);
    cyc++;
    #1;
    srst   = 1'b0;
    cq.delete();
    sb.delete();
    exp_pc = RST_PC;
    pend   = 1'b0;
    #1;
  endtask

  task automatic step();
    logic  exp_req;
    logic  acc;
    int    outst;
    pkt_t  p;
    creq_t c;
    predict_valid_next = 1'($urandom_range(0, 1));
    #1;
    outst   = cq.size() + (icache_data_valid ? 1 : 0);
    exp_req = (outst < MAXO) && (branch_occur || sb.size() < QD);
    if (branch_occur) begin
      exp_pc = branch_target;
      pend   = 1'b1;
    end
    chk("pc_now", 64'(pc_fetch_now_process), 64'(exp_pc));
    chk("request", 64'(icache_read_request), 64'(exp_req));
    chk("flush", 64'(icache_flush), 64'(branch_occur));
    acc = exp_req && icache_accept;
    chk("pc_accept", 64'(pc_next_been_accept), 64'(acc));
    if (fetch_valid) begin
      chk("valid_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        chk("head_pc", 64'(fetch_pc), 64'(sb[0].pc));
        chk("head_inst", fetch_inst, sb[0].inst);
        chk("head_pred", 64'(fetch_predict_valid), 64'(sb[0].pred));
        if (fetch_result_been_accepted && !branch_occur) void'(sb.pop_front());
      end
    end
    if (branch_occur) sb.delete();
    if (acc) begin
      chk("icache_pc", 64'(icache_pc), 64'(exp_pc & ~32'h7));
      p.pc   = exp_pc;
      p.pred = branch_occur | pend | predict_valid_next;
      p.inst = mkdata(exp_pc);
      sb.push_back(p);
      c.pc  = icache_pc;
      c.due = cyc + 2;
      cq.push_back(c);
      exp_pc = (exp_pc & ~32'h7) + 32'd8;
      pend   = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    // In-order cache model: one response per cycle, two cycles after accept.
    if (cq.size() != 0 && cq[0].due <= cyc) begin
      icache_data_valid = 1'b1;
      icache_inst       = mkdata(cq[0].pc);
      void'(cq.pop_front());
    end else begin
      icache_data_valid = 1'b0;
      icache_inst       = '0;
    end
  endtask

  initial begin
    int n;
    srst = 1'b0;
    predict_valid_next = 1'b0;
    branch_occur = 1'b0;
    branch_target = '0;
    icache_accept = 1'b1;
    icache_data_valid = 1'b0;
    icache_inst = '0;
    fetch_result_been_accepted = 1'b1;
    exp_pc = RST_PC;
    pend = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", 64'(fetch_valid), 64'd0);
    chk("rst_pc", 64'(fetch_pc), 64'd0);
    chk("rst_inst", fetch_inst, 64'd0);
    chk("rst_pred", 64'(fetch_predict_valid), 64'd0);
    chk("rst_occ", 64'(fetch_occupancy), 64'd0);
    chk("rst_pc_now", 64'(pc_fetch_now_process), 64'(RST_PC));
    chk("rst_request", 64'(icache_read_request), 64'd1);

    // Streaming
    for (int i = 0; i < 20; i++) step();

    // Back-pressure: queue fills, requests stop
    fetch_result_been_accepted = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("bp_occ", 64'(fetch_occupancy), 64'd4);
    chk("bp_valid", 64'(fetch_valid), 64'd1);
    chk("bp_request", 64'(icache_read_request), 64'd0);
    fetch_result_been_accepted = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // Branch with two reads in flight: no request, redirect retried
    n = 0;
    while (!((cq.size() + (icache_data_valid ? 1 : 0)) == 2 && fetch_valid) && n < 30) begin
      step();
      n++;
    end
    chk("wait_two_inflight", 64'((cq.size() + (icache_data_valid ? 1 : 0)) == 2), 64'd1);
    branch_occur  = 1'b1;
    branch_target = 32'h2004;
    step();
    branch_occur = 1'b0;
    chk("br_occ", 64'(fetch_occupancy), 64'd0);
    chk("br_valid", 64'(fetch_valid), 64'd0);
    fetch_result_been_accepted = 1'b0;
    n = 0;
    while (!fetch_valid && n < 20) begin
      step();
      n++;
    end
    chk("br_head_pc", 64'(fetch_pc), 64'h2004);
    chk("br_head_pred", 64'(fetch_predict_valid), 64'd1);
    chk("br_head_inst", fetch_inst, mkdata(32'h2000));
    fetch_result_been_accepted = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Redirect accepted in the branch cycle itself
    icache_accept = 1'b0;
    for (int i = 0; i < 4; i++) step();
    icache_accept = 1'b1;
    branch_occur  = 1'b1;
    branch_target = 32'h3010;
    step();
    branch_occur = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Response, pop and branch together, then back-to-back branches
    fetch_result_been_accepted = 1'b0;
    n = 0;
    while (!(icache_data_valid && fetch_valid) && n < 20) begin
      step();
      n++;
    end
    chk("wait_sim_event", 64'(icache_data_valid && fetch_valid), 64'd1);
    fetch_result_been_accepted = 1'b1;
    branch_occur  = 1'b1;
    branch_target = 32'h4000;
    step();
    chk("sim_occ", 64'(fetch_occupancy), 64'd0);
    branch_target = 32'h5008;
    step();
    branch_target = 32'h6000;
    step();
    branch_occur = 1'b0;
    for (int i = 0; i < 15; i++) step();

    // Reset mid-stream
    fetch_result_been_accepted = 1'b0;
    n = 0;
    while (fetch_occupancy != 3'd3 && n < 20) begin
      step();
      n++;
    end
    chk("wait_occ3", 64'(fetch_occupancy), 64'd3);
    do_reset();
    chk("mrst_valid", 64'(fetch_valid), 64'd0);
    chk("mrst_occ", 64'(fetch_occupancy), 64'd0);
    chk("mrst_icache_pc", 64'(icache_pc), 64'(RST_PC));
    fetch_result_been_accepted = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Drain everything
    icache_accept = 1'b0;
    n = 0;
    while ((sb.size() != 0 || cq.size() != 0 || icache_data_valid) && n < 30) begin
      step();
      n++;
    end
    chk("drained", 64'(sb.size() + cq.size()), 64'd0);
    chk("final_valid", 64'(fetch_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
